display_scan_7seg: RTL and testbench
====================================

# display_scan_7seg

Time-multiplexed driver for the board's four-digit common-anode 7-segment display. It sits downstream of the switch/button decoding stage. It takes the four 4-bit digit values that stage produces, plus per-digit blank flags, and holds them in double-buffered registers. It then scans the digits at a fixed refresh rate, driving active-low `AN` and `SEG` so that all four digits appear lit at once.

## Interface
- `TICK_DIV`, default 100_000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load`  in  1  single-cycle strobe; captures `digits_i` and `blank_i` into the pending buffer.
- `digits_i`  in  16  digit values; digit k = `digits_i[4k+3:4k]`; digit 0 is the rightmost.
- `blank_i`  in  4  bit k = 1 turns digit k dark.
- `AN`  out  4  anode enables, active-low; bit k drives digit k.
- `SEG`  out  7  cathodes, active-low; `SEG[0]`=a … `SEG[6]`=g.
- `frame_o`  out  1  one-cycle pulse at each completed 4-digit scan.

## Operation
- **Prescaler:** `div_cnt` counts 0..TICK_DIV-1 and then wraps. The wrap cycle (`div_cnt == TICK_DIV-1`) is the slot boundary.
- **Slot counter:** 2-bit `slot` increments mod 4 at each boundary (3 → 0 wraps).
- **Double buffer:**
  - `load` writes the pending regs (`pend_dig`, `pend_blk`) and sets `pend_vld`.
  - At a boundary with `pend_vld`=1, pending is copied to active (`act_dig`, `act_blk`) and `pend_vld` is cleared.
  - Displayed data never changes mid-slot.
- **Simultaneous events:**
  - `load` on a boundary cycle: the inputs go straight to active at that edge (bypass), and `pend_vld` stays 0.
  - Two `load`s before a boundary: the last one wins.
- **Output stage** (registered, from the current `slot` and active regs):
  - When `act_blk[slot]`=0: `AN` = ~(4'b0001 << slot) and `SEG` = hex decode of `act_dig[slot]`.
  - When `act_blk[slot]`=1: `AN` = 4'b1111 and `SEG` = 7'b1111111.
- **Hex decode** (gfedcba, active-low): 0 = 1000000, 1 = 1111001, 3 = 0110000, 6 = 0000010, 8 = 0000000, 9 = 0010000, A = 0001000, F = 0001110. All 16 codes are decoded; there is no don't-care.
- **frame_o:** asserted for the one cycle after the edge where `slot` wraps 3 → 0.
- **Reset** (any cycle, including mid-scan or with pending data):
  - Counters: `div_cnt`=0, `slot`=0.
  - Buffers: `pend_vld`=0, `act_dig`=0, `act_blk`=4'b1111, pending regs cleared.
  - Outputs: `AN`=4'b1111, `SEG`=7'b1111111, `frame_o`=0.
  - The display stays dark until the first `load` is committed.

## Timing
- `div_cnt`, `slot` and the active regs update on the same boundary edge. `AN`/`SEG` follow one cycle later, so at most one output change per TICK_DIV cycles plus the reset edge.
- **Load-to-display latency:** commit happens at the next boundary (1..TICK_DIV cycles after `load`). The new data reaches `AN`/`SEG` one cycle after commit, and only when the scan reaches the changed digit.
- **Full scan:** 4·TICK_DIV cycles, so `frame_o` period = 4·TICK_DIV.
- **`AN` transitions:** exactly one bit is low at a time, except during blanking.
- `load` must be a single-cycle strobe. A held `load` re-captures every cycle, which is legal.

## Structure
- **Package `display_pkg`:**
  - Constants: `SEG_OFF` = 7'b1111111, `AN_OFF` = 4'b1111, `N_DIGITS` = 4.
  - Typedefs: `seg_t` (logic [6:0]), `digit_t` (logic [3:0]).
  - Function `hex_to_seg(digit_t) → seg_t`.
- **Sub-module `hex7seg`:** purely combinational wrapper around `hex_to_seg`, reused by other display users. The top instantiates one, muxed by `slot`.
- **Top:** contains the prescaler, slot counter, double buffer and output registers.

## Test plan
Sims use TICK_DIV = 4 throughout.
- **Reset:** assert `rst` 3 cycles, then release → `AN`=1111, `SEG`=1111111, `frame_o`=0; dark for 20 cycles with no `load`.
- **Basic scan:** `load` with `digits_i`=16'h9863, `blank_i`=0 → `AN` cycles 1110/1101/1011/0111 every 4 cycles; `SEG` = 0110000, 0000010, 0000000, 0010000; `frame_o` pulses every 16 cycles.
- **Blanking:** `load` with `digits_i`=16'hF0A1, `blank_i`=4'b0100 → slot 2 shows `AN`=1111, `SEG`=1111111; slot 3 shows `SEG`=0001110.
- **Mid-slot load:** `load` 16'h1111 one cycle after a boundary → outputs unchanged until the next boundary, then digit `SEG`=1111001; nothing changes mid-slot.
- **Boundary bypass:** `load` on the boundary cycle → new value visible one cycle later; with a second `load` 1 cycle earlier, only the later value is ever displayed.
- **Reset mid-scan:** assert `rst` in slot 2 with pending data → all outputs return to reset values next edge; pending data is never displayed.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types, constants and the hex-to-segment decoder for
// the seven-segment display drivers.
//   seg_t      : 7-bit cathode pattern, active-low, bit 0 = a ... bit 6 = g
//   digit_t    : 4-bit hex digit
//   hex_to_seg : hex digit -> active-low gfedcba pattern
package display_pkg;

    localparam int N_DIGITS = 4;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] digit_t;

    localparam seg_t       SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Patterns are listed as gfedcba; a 0 lights the segment.
    function automatic seg_t hex_to_seg(input digit_t d);
        seg_t s;
        s = SEG_OFF;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex digit to active-low seven-segment decoder.
//   digit : input  4-bit hex value
//   seg   : output 7-bit cathode pattern, active-low, seg[0] = a ... seg[6] = g
module hex7seg
    import display_pkg::*;
(
    input  digit_t digit,
    output seg_t   seg
);

    assign seg = hex_to_seg(digit);

endmodule

// File: rtl/display_scan_7seg.sv
// display_scan_7seg: time-multiplexed driver for a four-digit common-anode
// seven-segment display with double-buffered digit/blank registers.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   load     : one-cycle strobe capturing digits_i / blank_i into the pending buffer
//   digits_i : four 4-bit digits, digit k = digits_i[4k+3:4k], digit 0 rightmost
//   blank_i  : bit k = 1 darkens digit k
//   AN       : anode enables, active-low, bit k = digit k
//   SEG      : cathodes, active-low, SEG[0] = a ... SEG[6] = g
//   frame_o  : one-cycle pulse after each completed four-digit scan
module display_scan_7seg
    import display_pkg::*;
#(
    parameter int TICK_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_i,
    input  logic [3:0]  blank_i,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        frame_o
);

    localparam int                CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  DIV_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       slot;
    logic [15:0]      pend_dig;
    logic [3:0]       pend_blk;
    logic             pend_vld;
    logic [15:0]      act_dig;
    logic [3:0]       act_blk;

    logic             boundary;
    digit_t           cur_dig;
    seg_t             cur_seg;

    assign boundary = (div_cnt == DIV_MAX);
    assign cur_dig  = act_dig[{slot, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .digit (cur_dig),
        .seg   (cur_seg)
    );

    // Stage 0: prescaler, slot counter and double buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            slot     <= 2'd0;
            pend_dig <= '0;
            pend_blk <= '0;
            pend_vld <= 1'b0;
            act_dig  <= '0;
            act_blk  <= AN_OFF;
        end else begin
            div_cnt <= boundary ? '0 : div_cnt + 1'b1;
            if (load) begin
                pend_dig <= digits_i;
                pend_blk <= blank_i;
            end
            if (boundary) begin
                slot     <= slot + 2'd1;
                pend_vld <= 1'b0;
                // A load landing on the boundary bypasses the pending stage.
                if (load) begin
                    act_dig <= digits_i;
                    act_blk <= blank_i;
                end else if (pend_vld) begin
                    act_dig <= pend_dig;
                    act_blk <= pend_blk;
                end
            end else if (load) begin
                pend_vld <= 1'b1;
            end
        end
    end

    // Stage 1: registered display outputs from the current slot
    always_ff @(posedge clk) begin
        if (rst) begin
            AN      <= AN_OFF;
            SEG     <= SEG_OFF;
            frame_o <= 1'b0;
        end else begin
            frame_o <= boundary && (slot == 2'd3);
            if (act_blk[slot]) begin
                AN  <= AN_OFF;
                SEG <= SEG_OFF;
            end else begin
                AN  <= ~(4'b0001 << slot);
                SEG <= cur_seg;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_7seg.sv
// tb_display_scan_7seg: scoreboard bench for display_scan_7seg with TICK_DIV = 4.
// Cycle n counts rising edges since the last edge that sampled rst high
// (n = 0 is that reset edge). Slot boundaries are the edges n = 4, 8, 12, ...;
// the outputs seen after edge n show slot ((n-1)/4) mod 4 of the data that was
// active before that edge, and frame_o is high after edges n = 16, 32, ...
module tb_display_scan_7seg;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] digits_i;
    logic [3:0]  blank_i;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        frame_o;

    typedef struct {
        int         ep;
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       frm;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   epoch    = 1;
    int   checks   = 0;
    int   failures = 0;

    display_scan_7seg #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .digits_i (digits_i),
        .blank_i  (blank_i),
        .AN       (AN),
        .SEG      (SEG),
        .frame_o  (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Hand-written active-low gfedcba table.
    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected outputs for cycles n0..n1 while (dig, blk) is the active data.
    // e.g. 9863 at n=25..28 -> slot 2: AN=1011 SEG=0000000;
    //      n=29..32 -> slot 3: AN=0111 SEG=0010000; n=33..36 -> 1110/0110000.
    task automatic push_range(input int ep, input int n0, input int n1,
                              input logic [15:0] dig, input logic [3:0] blk);
        exp_t e;
        int   s;
        for (int n = n0; n <= n1; n++) begin
            s     = (n == 0) ? 0 : ((n - 1) / 4) % 4;
            e.ep  = ep;
            e.n   = n;
            e.an  = blk[s] ? 4'b1111 : ~(4'b0001 << s);
            e.seg = blk[s] ? 7'b1111111 : seg_ref(dig[s*4 +: 4]);
            e.frm = (n > 0) && (n % 16 == 0);
            sbq.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        int budget;
        budget = 300;
        while (cyc != n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (cyc != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc: cycle=%0d required=%0d", cyc, n);
        end
    endtask

    task automatic do_load(input logic [15:0] dig, input logic [3:0] blk);
        load     = 1'b1;
        digits_i = dig;
        blank_i  = blk;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Monitor: compares the scoreboard head against the DUT each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq[0];
                if (e.ep < epoch || (e.ep == epoch && e.n < cyc)) begin
                    checks++;
                    failures++;
                    $display("FAIL missed ep=%0d n=%0d: cycle=%0d", e.ep, e.n, cyc);
                    void'(sbq.pop_front());
                end else if (e.ep == epoch && e.n == cyc) begin
                    checks++;
                    if (AN !== e.an || SEG !== e.seg || frame_o !== e.frm) begin
                        failures++;
                        $display("FAIL scan ep=%0d n=%0d: AN=%b SEG=%b frame=%b required AN=%b SEG=%b frame=%b",
                                 e.ep, e.n, AN, SEG, frame_o, e.an, e.seg, e.frm);
                    end
                    void'(sbq.pop_front());
                end else begin
                    break;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst      = 1'b1;
        load     = 1'b0;
        digits_i = '0;
        blank_i  = '0;

        // Reset and release: dark until the first commit at edge 24.
        push_range(1, 0, 24, 16'h0000, 4'b1111);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic scan: loaded mid-slot at edge 22, committed at edge 24.
        wait_cyc(21);
        push_range(1, 25, 44, 16'h9863, 4'b0000);
        do_load(16'h9863, 4'b0000);

        // Blanking digit 2: committed at edge 44.
        wait_cyc(41);
        push_range(1, 45, 72, 16'hF0A1, 4'b0100);
        do_load(16'hF0A1, 4'b0100);

        // Load one cycle after the edge-68 boundary: slot 1 keeps 'A' until edge 72.
        wait_cyc(68);
        push_range(1, 73, 88, 16'h1111, 4'b0000);
        do_load(16'h1111, 4'b0000);

        // 3333 at edge 87, then 6666 on the edge-88 boundary: only 6666 is shown.
        wait_cyc(86);
        push_range(1, 89, 106, 16'h6666, 4'b0000);
        load     = 1'b1;
        digits_i = 16'h3333;
        blank_i  = 4'b0000;
        @(negedge clk);
        digits_i = 16'h6666;
        @(negedge clk);
        load     = 1'b0;

        // Reset in slot 2 with 8888 pending: it must never appear.
        wait_cyc(105);
        do_load(16'h8888, 4'b0000);
        epoch = 2;
        rst   = 1'b1;
        push_range(2, 0, 24, 16'h0000, 4'b1111);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(24);

        budget = 20;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
